ntt_mod_reduce_pipe: RTL
========================

// Module: ntt_mod_reduce_pipe
// PURPOSE
//  Pipelined Barrett reduction stage consuming the unreduced 2*DATA_WIDTH-bit
//  butterfly result pair (data1/data2) from the NTT butterfly and returning both
//  lanes reduced mod Q as DATA_WIDTH-bit values. Sits directly downstream of the
//  NTT butterfly; output feeds the INTT butterfly or coefficient write-back.
//  Two lanes run in lockstep under one valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH  32         width of reduced outputs; inputs are 2*DATA_WIDTH
//  Q           998244353  prime modulus; K = $clog2(Q) must satisfy K <= DATA_WIDTH
//  (derived)   K, MU = floor(2^(2K)/Q) are localparams, not overridable
// PORTS
//  clk_i        in   1             clock, rising edge
//  reset_i      in   1             asynchronous reset, active-high
//  valid_i      in   1             input pair valid
//  ready_o      out  1             stage can accept a pair this cycle
//  data1_i      in   2*DATA_WIDTH  lane-1 unreduced value x1
//  data2_i      in   2*DATA_WIDTH  lane-2 unreduced value x2
//  valid_o      out  1             output pair valid
//  ready_i      in   1             downstream accepts output pair
//  data1_o      out  DATA_WIDTH    x1 mod Q, zero-extended from K bits
//  data2_o      out  DATA_WIDTH    x2 mod Q, zero-extended from K bits
//  busy_o       out  1             any pipeline stage holds a valid pair
//  range_err_o  out  1             sticky: an accepted input had bits >= 2K set
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits, data regs,
//    data1_o/data2_o, valid_o, busy_o, range_err_o = 0; ready_o = 1 after reset.
//  - Handshake: transfer in when valid_i && ready_o; out when valid_o && ready_i.
//    adv = !valid_o || ready_i; ready_o = adv. Whole pipe advances on adv, holds
//    all regs otherwise. Outputs stable while valid_o && !ready_i.
//  - Bubbles are not compressed; order strictly preserved; no drop, no duplicate.
//  - Latency 4 cycles from accepting edge to valid_o with ready_i held high;
//    throughput 1 pair/cycle.
//  - Per lane: S1 reg x[2K-1:0]; q1 = x >> (K-1).
//    S2 q3 = (q1*MU) >> (K+1). S3 r = x - q3*Q, computed on K+2 bits.
//    S4 r -= Q if r >= Q, twice (r < 3Q before correction); register to output.
//    Result exactly x mod Q for every x < 2^(2K).
//  - Range: if x[2*DATA_WIDTH-1:2K] != 0 on an accepted input, range_err_o sets
//    the next cycle and stays set until reset. Lane reduces x[2K-1:0] anyway.
//  - valid_i while ready_o = 0: input ignored; upstream must hold it.
//  - Reset mid-stream: in-flight pairs discarded. No stale valid_o after release.
//  - busy_o = OR of S1..S4 valid bits (S4 valid == valid_o).
// STRUCTURE
//  - Shared package ntt_pkg: Q, K, MU function (barrett_mu(Q)), lane data typedefs
//    (wide_t = logic [2*DATA_WIDTH-1:0], coef_t = logic [DATA_WIDTH-1:0]).
//  - Sub-module barrett_lane: one lane's S1-S4 datapath with enable input,
//    instantiated twice. Top holds valid pipe, adv/ready, range flag.
//  - No reductions outside S1-S4; multipliers registered on both sides.
// TESTING (Q = 998244353, ready_i = 1 unless noted)
//  1 x1=0, x2=Q -> data1_o=0, data2_o=0, valid_o exactly 4 cycles after accept.
//  2 x1=Q-1, x2=(Q-1)^2 -> 998244352, 1; x1=2Q+5 -> 5.
//  3 Stream 16 random x < 2^60, valid_i every cycle -> 16 outputs on 16 consecutive
//    cycles, each matching a golden x mod Q model, in order.
//  4 Stream 6 pairs, ready_i=0 for 3 cycles mid-stream -> ready_o=0 those cycles,
//    data_o held stable; all 6 pairs delivered in order, none lost or duplicated.
//  5 x1 = 2^60 (bit 60 set) -> range_err_o=1 next cycle, stays 1 through 10 more
//    clean pairs; cleared only by reset_i.
//  6 3 pairs in flight, pulse reset_i mid-cycle -> valid_o, busy_o fall at once
//    (async); after release no output appears until a new pair is accepted.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, Barrett factor helper and lane data types for the NTT reduction path.
package ntt_pkg;

    localparam int              NTT_DATA_WIDTH = 32;
    localparam longint unsigned NTT_Q          = 64'd998244353;
    localparam int              NTT_K          = $clog2(NTT_Q);

    // floor(2^(2k) / q), evaluated at elaboration only
    function automatic logic [127:0] barrett_mu(input longint unsigned q, input int k);
        logic [127:0] num;
        num = 128'd1 << (2 * k);
        return num / 128'(q);
    endfunction

    typedef logic [2*NTT_DATA_WIDTH-1:0] wide_t;
    typedef logic [NTT_DATA_WIDTH-1:0]   coef_t;

endpackage

// File: rtl/barrett_lane.sv
// One lane of the four-stage Barrett reduction datapath; all stages advance together on en_i.
// S1 input reg, S2 quotient estimate, S3 remainder, S4 final correction to output.
module barrett_lane
    import ntt_pkg::*;
#(
    parameter int              DATA_WIDTH = NTT_DATA_WIDTH,
    parameter longint unsigned Q          = NTT_Q,
    localparam int             K          = $clog2(Q)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic [2*K-1:0]        x_i,
    output logic [DATA_WIDTH-1:0] r_o
);

    localparam int QW = K + 1;
    localparam int RW = K + 2;
    localparam int MW = K + 2;
    localparam int PW = QW + MW;
    localparam logic [127:0]  MU   = barrett_mu(Q, K);
    localparam logic [MW-1:0] MU_C = MW'(MU);
    localparam logic [RW-1:0] Q_C  = RW'(Q);

    logic [2*K-1:0] s1_x_q;
    logic [RW-1:0]  s2_x_q;
    logic [RW-1:0]  s2_q3_q;
    logic [RW-1:0]  s3_r_q;
    logic [RW-1:0]  s4_r_q;

    logic [QW-1:0]  q1;
    logic [PW-1:0]  prod1;
    logic [RW-1:0]  q3_d;
    logic [RW-1:0]  r_d;
    logic [RW-1:0]  r_fix_d;

    assign q1    = s1_x_q[2*K-1:K-1];
    assign prod1 = PW'(q1) * PW'(MU_C);
    assign q3_d  = RW'(prod1 >> (K + 1));

    // True remainder is below 3Q < 2^(K+2), so the low K+2 bits of both terms suffice
    assign r_d = s2_x_q - RW'(s2_q3_q * Q_C);

    always_comb begin
        r_fix_d = s3_r_q;
        if (r_fix_d >= Q_C) r_fix_d = r_fix_d - Q_C;
        if (r_fix_d >= Q_C) r_fix_d = r_fix_d - Q_C;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_x_q  <= '0;
            s2_x_q  <= '0;
            s2_q3_q <= '0;
            s3_r_q  <= '0;
            s4_r_q  <= '0;
        end else if (en_i) begin
            s1_x_q  <= x_i;
            s2_x_q  <= s1_x_q[RW-1:0];
            s2_q3_q <= q3_d;
            s3_r_q  <= r_d;
            s4_r_q  <= r_fix_d;
        end
    end

    assign r_o = DATA_WIDTH'(s4_r_q);

endmodule

// File: rtl/ntt_mod_reduce_pipe.sv
// Two-lane Barrett mod-Q reduction pipe behind one valid/ready handshake.
// Latency 4 cycles, 1 pair/cycle; the whole pipe stalls when valid_o is held by !ready_i.
module ntt_mod_reduce_pipe
    import ntt_pkg::*;
#(
    parameter int              DATA_WIDTH = NTT_DATA_WIDTH,
    parameter longint unsigned Q          = NTT_Q
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [2*DATA_WIDTH-1:0] data1_i,
    input  logic [2*DATA_WIDTH-1:0] data2_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [DATA_WIDTH-1:0]   data1_o,
    output logic [DATA_WIDTH-1:0]   data2_o,
    output logic                    busy_o,
    output logic                    range_err_o
);

    localparam int K = $clog2(Q);

    logic [3:0] vld_q;
    logic       range_err_q;
    logic       range_err_d;
    logic       adv;
    logic       accept;
    logic       upper_hit;

    assign adv     = !vld_q[3] || ready_i;
    assign ready_o = adv;
    assign accept  = valid_i && adv;
    assign valid_o = vld_q[3];
    assign busy_o  = |vld_q;

    if (DATA_WIDTH > K) begin : g_upper
        assign upper_hit = (|data1_i[2*DATA_WIDTH-1:2*K]) || (|data2_i[2*DATA_WIDTH-1:2*K]);
    end else begin : g_no_upper
        assign upper_hit = 1'b0;
    end

    assign range_err_d = range_err_q || (accept && upper_hit);

    // Bubbles travel with the data, so the valid pipe shifts on every advance
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            vld_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
            if (adv) vld_q <= {vld_q[2:0], valid_i};
        end
    end

    assign range_err_o = range_err_q;

    barrett_lane #(.DATA_WIDTH(DATA_WIDTH), .Q(Q)) u_lane1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (adv),
        .x_i     (data1_i[2*K-1:0]),
        .r_o     (data1_o)
    );

    barrett_lane #(.DATA_WIDTH(DATA_WIDTH), .Q(Q)) u_lane2 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (adv),
        .x_i     (data2_i[2*K-1:0]),
        .r_o     (data2_o)
    );

endmodule
